// File: rtl/hilo_mul_ctrl.sv
// HI/LO register file and sequencing controller for an external iterative multiplier.
// MULTU walks IDLE -> LOAD -> RUN (MUL_CYCLES steps) -> CAPTURE; HI/LO moves complete in one IDLE cycle.
module hilo_mul_ctrl #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_load,
    output logic        mul_en,
    input  logic [63:0] mul_product,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MFHI  = 3'd2;
    localparam logic [2:0] OP_MFLO  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [5:0] LAST_CNT = 6'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        busy_q, busy_d;
    logic        op_known;
    logic        accept;

    // Only real opcodes stall; NOPs pass through even while a multiply is running.
    assign op_known = (req_op >= OP_MULTU) && (req_op <= OP_MTLO);
    assign stall    = req_valid && (state_q != IDLE) && op_known && !flush;
    assign accept   = req_valid && !stall && !flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mul_load   = 1'b0;
        mul_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_MULTU: begin
                            mul_a_d = op_a;
                            mul_b_d = op_b;
                            state_d = LOAD;
                        end
                        OP_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                mul_load = 1'b1;
                cnt_d    = 6'd0;
                state_d  = RUN;
            end
            RUN: begin
                mul_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 6'd0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            CAPTURE: begin
                hi_d    = mul_product[63:32];
                lo_d    = mul_product[31:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts any sequence, including the HI/LO write of a CAPTURE cycle.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
